// File: rtl/shift_unit_pkg.sv
// rtl/shift_unit_pkg.sv - shared types for the multicycle shift unit
package shift_unit_pkg;

  typedef enum logic [2:0] {
    OP_LOAD = 3'd0,
    OP_SLL  = 3'd1,
    OP_SRL  = 3'd2,
    OP_SRA  = 3'd3,
    OP_ROL  = 3'd4,
    OP_ROR  = 3'd5
  } op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Reserved encodings 110/111 behave as LOAD.
  function automatic op_t decode_op(input logic [2:0] raw);
    return (raw > 3'd5) ? OP_LOAD : op_t'(raw);
  endfunction

endpackage

// File: rtl/shift_step.sv
// rtl/shift_step.sv - one combinational shift/rotate step by k bits
module shift_step
  import shift_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int KW    = 1
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic [KW-1:0]    i_k,
  input  op_t              i_op,
  output logic [WIDTH-1:0] o_data
);

  // A shift by WIDTH yields zero, so k==0 rotates back to the input unchanged.
  always_comb begin
    case (i_op)
      OP_SLL:  o_data = i_data << i_k;
      OP_SRL:  o_data = i_data >> i_k;
      OP_SRA:  o_data = $signed(i_data) >>> i_k;
      OP_ROL:  o_data = (i_data << i_k) | (i_data >> (WIDTH - int'(i_k)));
      OP_ROR:  o_data = (i_data >> i_k) | (i_data << (WIDTH - int'(i_k)));
      default: o_data = i_data;
    endcase
  end

endmodule

// File: rtl/shift_unit_seq.sv
// rtl/shift_unit_seq.sv - multicycle shift unit with source mux and start/busy/done handshake
module shift_unit_seq
  import shift_unit_pkg::*;
#(
  parameter  int WIDTH   = 32,
  parameter  int NSRC    = 3,
  parameter  int STEP    = 1,
  parameter  int SEL_W   = 3,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [SEL_W-1:0]      src_sel,
  input  logic [NSRC*WIDTH-1:0] src_data,
  input  logic [SHAMT_W-1:0]    shamt,
  input  logic [2:0]            op,
  output logic                  busy,
  output logic                  done,
  output logic [WIDTH-1:0]      result,
  output logic                  sel_err
);

  localparam int KW = $clog2(STEP) + 1;

  state_t             r_state;
  state_t             w_next;
  op_t                r_op;
  op_t                w_op;
  logic [SHAMT_W-1:0] r_rem;
  logic [WIDTH-1:0]   r_result;
  logic               r_sel_err;
  logic [WIDTH-1:0]   w_src;
  logic [WIDTH-1:0]   w_shifted;
  logic               w_sel_bad;
  logic               w_accept;
  logic [KW-1:0]      w_k;

  assign w_accept = start && (r_state != SHIFT);
  assign w_op     = decode_op(op);

  always_comb begin
    w_src     = '0;
    w_sel_bad = 1'b1;
    for (int i = 0; i < NSRC; i++) begin
      if (src_sel == SEL_W'(i)) begin
        w_src     = src_data[i*WIDTH +: WIDTH];
        w_sel_bad = 1'b0;
      end
    end
  end

  always_comb begin
    if (int'(r_rem) >= STEP) w_k = KW'(STEP);
    else                     w_k = KW'(r_rem);
  end

  shift_step #(
    .WIDTH (WIDTH),
    .KW    (KW)
  ) u_step (
    .i_data (r_result),
    .i_k    (w_k),
    .i_op   (r_op),
    .o_data (w_shifted)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // SHIFT always spends one cycle with rem==0 before DONE, which gives the load cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      SHIFT:   w_next = (r_rem == '0) ? DONE : SHIFT;
      default: w_next = w_accept ? SHIFT : IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_result  <= '0;
      r_rem     <= '0;
      r_op      <= OP_LOAD;
      r_sel_err <= 1'b0;
    end else if (w_accept) begin
      r_result  <= w_src;
      r_sel_err <= w_sel_bad;
      r_op      <= w_op;
      r_rem     <= (w_op == OP_LOAD) ? '0 : shamt;
    end else if (r_state == SHIFT && r_rem != '0) begin
      r_result  <= w_shifted;
      r_rem     <= r_rem - SHAMT_W'(w_k);
    end
  end

  always_comb begin
    busy = (r_state == SHIFT);
    done = (r_state == DONE);
  end

  assign result  = r_result;
  assign sel_err = r_sel_err;

endmodule
